// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the single MIPS32 datapath. Fetches, decodes
//   opc/func once per instruction, then walks EXEC / MEM / writeback states
//   issuing Moore strobes. Memory states wait on the dm ready handshake and
//   abort with mem_err after MEM_TIMEOUT cycles without ready.
//   Optional feature macro: PERF_CNT_EN (retired-instruction counter on
//   instr_cnt; when undefined instr_cnt is tied to zero).
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opc,
    input  logic [5:0]  func,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [2:0]  npc_slc,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrc,
    output logic        extop,
    output logic        luiop,
    output logic [2:0]  aluop,
    output logic        jalop,
    output logic        jalrop,
    output logic        memread,
    output logic        memwrite,
    output logic        retire,
    output logic        mem_err,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM_RD = 3'd3;
    localparam logic [2:0] S_MEM_WR = 3'd4;
    localparam logic [2:0] S_WB_ALU = 3'd5;
    localparam logic [2:0] S_WB_MEM = 3'd6;

    localparam logic [3:0] C_NOP  = 4'd0;
    localparam logic [3:0] C_J    = 4'd1;
    localparam logic [3:0] C_JAL  = 4'd2;
    localparam logic [3:0] C_JR   = 4'd3;
    localparam logic [3:0] C_JALR = 4'd4;
    localparam logic [3:0] C_ADDU = 4'd5;
    localparam logic [3:0] C_SUBU = 4'd6;
    localparam logic [3:0] C_ORI  = 4'd7;
    localparam logic [3:0] C_LUI  = 4'd8;
    localparam logic [3:0] C_LW   = 4'd9;
    localparam logic [3:0] C_SW   = 4'd10;
    localparam logic [3:0] C_BEQ  = 4'd11;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;

    localparam int             CW        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]  WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    // Map opcode/function fields to an instruction class; unknown encodings are NOPs.
    function automatic logic [3:0] decode_class(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] cls;
        cls = C_NOP;
        case (op)
            6'h00: begin
                case (fn)
                    6'h08:   cls = C_JR;
                    6'h09:   cls = C_JALR;
                    6'h21:   cls = C_ADDU;
                    6'h23:   cls = C_SUBU;
                    default: cls = C_NOP;
                endcase
            end
            6'h02:   cls = C_J;
            6'h03:   cls = C_JAL;
            6'h04:   cls = C_BEQ;
            6'h0D:   cls = C_ORI;
            6'h0F:   cls = C_LUI;
            6'h23:   cls = C_LW;
            6'h2B:   cls = C_SW;
            default: cls = C_NOP;
        endcase
        return cls;
    endfunction

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [3:0]    r_class;
    logic [3:0]    w_dec_class;
    logic [CW-1:0] r_wait_cnt;
    logic          w_wait_last;

    logic          w_ir_we, w_pc_we, w_regwrite, w_regdst, w_memtoreg;
    logic          w_alusrc, w_extop, w_luiop, w_jalop, w_jalrop;
    logic          w_memread, w_memwrite, w_retire, w_mem_err;
    logic [2:0]    w_npc_slc, w_aluop;

    // Only consulted in DECODE, where the instruction register has just been loaded.
    assign w_dec_class = decode_class(opc, func);
    assign w_wait_last = (r_wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the instruction class once in DECODE so later opc/func changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_class <= C_NOP;
        end else if (r_state == S_DECODE) begin
            r_class <= w_dec_class;
        end else begin
            r_class <= r_class;
        end
    end

    // Memory wait counter: advances while a MEM state stalls, zero everywhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (((r_state == S_MEM_RD) || (r_state == S_MEM_WR)) && (w_next_state == r_state)) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_dec_class)
                    C_J, C_JAL, C_JR, C_JALR, C_NOP: w_next_state = S_FETCH;
                    default:                          w_next_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (r_class)
                    C_LW:                        w_next_state = S_MEM_RD;
                    C_SW:                        w_next_state = S_MEM_WR;
                    C_ADDU, C_SUBU, C_ORI, C_LUI: w_next_state = S_WB_ALU;
                    default:                     w_next_state = S_FETCH;
                endcase
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    w_next_state = S_WB_MEM;
                end else if (w_wait_last) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready || w_wait_last) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEM_WR;
                end
            end
            S_WB_ALU: w_next_state = S_FETCH;
            S_WB_MEM: w_next_state = S_FETCH;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Moore strobes from state and registered class (DECODE uses the fresh decode).
    always_comb begin
        w_ir_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_npc_slc  = 3'd0;
        w_regwrite = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrc   = 1'b0;
        w_extop    = 1'b0;
        w_luiop    = 1'b0;
        w_aluop    = ALU_ADD;
        w_jalop    = 1'b0;
        w_jalrop   = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_retire   = 1'b0;
        w_mem_err  = 1'b0;

        // ALU controls stay valid from EXEC through the state that consumes the result.
        if ((r_state == S_EXEC) || (r_state == S_MEM_RD) ||
            (r_state == S_MEM_WR) || (r_state == S_WB_ALU)) begin
            case (r_class)
                C_SUBU: w_aluop = ALU_SUB;
                C_BEQ:  w_aluop = ALU_SUB;
                C_ORI:  begin w_aluop = ALU_OR; w_alusrc = 1'b1; end
                C_LUI:  begin w_aluop = ALU_OR; w_alusrc = 1'b1; w_luiop = 1'b1; end
                C_LW:   begin w_alusrc = 1'b1; w_extop = 1'b1; end
                C_SW:   begin w_alusrc = 1'b1; w_extop = 1'b1; end
                default: w_aluop = ALU_ADD;
            endcase
        end else begin
            w_aluop = ALU_ADD;
        end

        case (r_state)
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_pc_we = 1'b1;
            end
            S_DECODE: begin
                case (w_dec_class)
                    C_J:    begin w_pc_we = 1'b1; w_npc_slc = 3'd2; w_retire = 1'b1; end
                    C_JAL:  begin w_pc_we = 1'b1; w_npc_slc = 3'd2; w_retire = 1'b1;
                                  w_regwrite = 1'b1; w_jalop = 1'b1; end
                    C_JR:   begin w_pc_we = 1'b1; w_npc_slc = 3'd3; w_retire = 1'b1; end
                    C_JALR: begin w_pc_we = 1'b1; w_npc_slc = 3'd3; w_retire = 1'b1;
                                  w_regwrite = 1'b1; w_jalrop = 1'b1; w_regdst = 1'b1; end
                    C_NOP:  w_retire = 1'b1;
                    default: w_retire = 1'b0;
                endcase
            end
            S_EXEC: begin
                if (r_class == C_BEQ) begin
                    w_pc_we   = alu_zero;
                    w_npc_slc = 3'd1;
                    w_retire  = 1'b1;
                end else begin
                    w_retire  = 1'b0;
                end
            end
            S_MEM_RD: begin
                w_memread = 1'b1;
                if (!mem_ready && w_wait_last) begin
                    w_mem_err = 1'b1;
                end else begin
                    w_mem_err = 1'b0;
                end
            end
            S_MEM_WR: begin
                w_memwrite = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                end else if (w_wait_last) begin
                    w_mem_err = 1'b1;
                end else begin
                    w_retire = 1'b0;
                end
            end
            S_WB_ALU: begin
                w_regwrite = 1'b1;
                w_regdst   = (r_class == C_ADDU) || (r_class == C_SUBU);
                w_retire   = 1'b1;
            end
            S_WB_MEM: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_retire   = 1'b1;
            end
            default: w_retire = 1'b0;
        endcase
    end

    // Outputs are forced low the moment reset asserts, without waiting for a clock.
    assign ir_we    = reset & w_ir_we;
    assign pc_we    = reset & w_pc_we;
    assign npc_slc  = reset ? w_npc_slc : 3'd0;
    assign regwrite = reset & w_regwrite;
    assign regdst   = reset & w_regdst;
    assign memtoreg = reset & w_memtoreg;
    assign alusrc   = reset & w_alusrc;
    assign extop    = reset & w_extop;
    assign luiop    = reset & w_luiop;
    assign aluop    = reset ? w_aluop : 3'd0;
    assign jalop    = reset & w_jalop;
    assign jalrop   = reset & w_jalrop;
    assign memread  = reset & w_memread;
    assign memwrite = reset & w_memwrite;
    assign retire   = reset & w_retire;
    assign mem_err  = reset & w_mem_err;
    assign state    = r_state;

`ifdef PERF_CNT_EN
    logic [31:0] r_instr_cnt;

    // Retired-instruction counter; wraps naturally, aborts never count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_cnt <= 32'h0;
        end else if (w_retire) begin
            r_instr_cnt <= r_instr_cnt + 32'h1;
        end else begin
            r_instr_cnt <= r_instr_cnt;
        end
    end

    assign instr_cnt = r_instr_cnt;
`else
    assign instr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
//   Directed vector table for every instruction class plus hand-written
//   sequences for memory waits, timeout abort, ready-on-timeout and reset
//   during a memory wait.
module tb_multicycle_sequencer;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic [2:0] npc;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       asrc;
        logic       ext;
        logic       lui;
        logic [2:0] aop;
        logic       jal;
        logic       jalr;
        logic       mrd;
        logic       mwr;
        logic       ret;
        logic       err;
        logic [2:0] st;
    } outs_t;

    typedef struct {
        logic [5:0] opc;
        logic [5:0] func;
        logic       zero;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opc, func;
    logic        alu_zero, mem_ready;
    logic        ir_we, pc_we, regwrite, regdst, memtoreg, alusrc, extop, luiop;
    logic        jalop, jalrop, memread, memwrite, retire, mem_err;
    logic [2:0]  npc_slc, aluop, state;
    logic [31:0] instr_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[48];
    int   n_vec = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .opc(opc), .func(func),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .npc_slc(npc_slc), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrc(alusrc), .extop(extop),
        .luiop(luiop), .aluop(aluop), .jalop(jalop), .jalrop(jalrop),
        .memread(memread), .memwrite(memwrite), .retire(retire),
        .mem_err(mem_err), .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // field order: ir pc npc | rw rd m2r | asrc ext lui | aop | jal jalr mrd mwr ret err | st
    localparam outs_t E_F     = '{1'b1,1'b1,3'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0};
    localparam outs_t E_D0    = '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd1};
    localparam outs_t E_ZERO  = '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0};
    localparam outs_t E_MEMEX = '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd2};
    localparam outs_t E_MRD   = '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd3};
    localparam outs_t E_WBM   = '{1'b0,1'b0,3'd0, 1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd6};
    localparam outs_t E_MWW   = '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd4};
    localparam outs_t E_MWRET = '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 3'd4};
    localparam outs_t E_MWERR = '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 3'd4};
    localparam outs_t E_JAL   = '{1'b0,1'b1,3'd2, 1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd1};
    localparam outs_t E_NOPD  = '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd1};

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input outs_t exp);
        tbl[n_vec] = '{op, fn, z, rdy, exp};
        n_vec = n_vec + 1;
    endtask

    // Drive inputs for the current cycle, compare outputs, advance to the next negedge.
    task automatic step(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input outs_t exp);
        outs_t act;
        opc = op; func = fn; alu_zero = z; mem_ready = rdy;
        #1;
        act = {ir_we, pc_we, npc_slc, regwrite, regdst, memtoreg, alusrc, extop, luiop,
               aluop, jalop, jalrop, memread, memwrite, retire, mem_err, state};
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: outputs got %h want %h", name, act, exp);
        end
        @(negedge clk);
    endtask

    task automatic check_cnt(input string name, input logic [31:0] want_perf);
        logic [31:0] want;
`ifdef PERF_CNT_EN
        want = want_perf;
`else
        want = 32'h0 & want_perf;
`endif
        n_cmp = n_cmp + 1;
        if (instr_cnt !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: instr_cnt got %0d want %0d", name, instr_cnt, want);
        end
    endtask

    initial begin
        reset = 1'b0; opc = 6'h00; func = 6'h00; alu_zero = 1'b0; mem_ready = 1'b0;

        // addu: mem_ready held high to show it is ignored
        add(6'h00, 6'h21, 1'b0, 1'b1, E_F);
        add(6'h00, 6'h21, 1'b0, 1'b1, E_D0);
        add(6'h00, 6'h21, 1'b0, 1'b1, '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd2});
        add(6'h00, 6'h21, 1'b0, 1'b1, '{1'b0,1'b0,3'd0, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd5});
        // subu
        add(6'h00, 6'h23, 1'b0, 1'b0, E_F);
        add(6'h00, 6'h23, 1'b0, 1'b0, E_D0);
        add(6'h00, 6'h23, 1'b0, 1'b0, '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd2});
        add(6'h00, 6'h23, 1'b0, 1'b0, '{1'b0,1'b0,3'd0, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 3'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd5});
        // ori
        add(6'h0D, 6'h00, 1'b0, 1'b0, E_F);
        add(6'h0D, 6'h00, 1'b0, 1'b0, E_D0);
        add(6'h0D, 6'h00, 1'b0, 1'b0, '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd2});
        add(6'h0D, 6'h00, 1'b0, 1'b0, '{1'b0,1'b0,3'd0, 1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 3'd2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd5});
        // lui
        add(6'h0F, 6'h00, 1'b0, 1'b0, E_F);
        add(6'h0F, 6'h00, 1'b0, 1'b0, E_D0);
        add(6'h0F, 6'h00, 1'b0, 1'b0, '{1'b0,1'b0,3'd0, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 3'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd2});
        add(6'h0F, 6'h00, 1'b0, 1'b0, '{1'b0,1'b0,3'd0, 1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1, 3'd2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd5});
        // beq taken / not taken
        add(6'h04, 6'h00, 1'b1, 1'b0, E_F);
        add(6'h04, 6'h00, 1'b1, 1'b0, E_D0);
        add(6'h04, 6'h00, 1'b1, 1'b0, '{1'b0,1'b1,3'd1, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd2});
        add(6'h04, 6'h00, 1'b0, 1'b0, E_F);
        add(6'h04, 6'h00, 1'b0, 1'b0, E_D0);
        add(6'h04, 6'h00, 1'b0, 1'b0, '{1'b0,1'b0,3'd1, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd2});
        // j, jal, jr, jalr
        add(6'h02, 6'h00, 1'b0, 1'b0, E_F);
        add(6'h02, 6'h00, 1'b0, 1'b0, '{1'b0,1'b1,3'd2, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd1});
        add(6'h03, 6'h00, 1'b0, 1'b0, E_F);
        add(6'h03, 6'h00, 1'b0, 1'b0, E_JAL);
        add(6'h00, 6'h08, 1'b0, 1'b0, E_F);
        add(6'h00, 6'h08, 1'b0, 1'b0, '{1'b0,1'b1,3'd3, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd1});
        add(6'h00, 6'h09, 1'b0, 1'b0, E_F);
        add(6'h00, 6'h09, 1'b0, 1'b0, '{1'b0,1'b1,3'd3, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 3'd0, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 3'd1});
        // illegal opcode and illegal R-type func: retire only
        add(6'h3F, 6'h00, 1'b0, 1'b0, E_F);
        add(6'h3F, 6'h00, 1'b0, 1'b0, E_NOPD);
        add(6'h00, 6'h00, 1'b0, 1'b0, E_F);
        add(6'h00, 6'h00, 1'b0, 1'b0, E_NOPD);
        // sw, ready on first MEM cycle
        add(6'h2B, 6'h00, 1'b0, 1'b0, E_F);
        add(6'h2B, 6'h00, 1'b0, 1'b0, E_D0);
        add(6'h2B, 6'h00, 1'b0, 1'b0, E_MEMEX);
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_MWRET);
        // lw, opc switched to sw after DECODE must be ignored
        add(6'h23, 6'h00, 1'b0, 1'b0, E_F);
        add(6'h23, 6'h00, 1'b0, 1'b0, E_D0);
        add(6'h2B, 6'h00, 1'b0, 1'b0, E_MEMEX);
        add(6'h2B, 6'h00, 1'b0, 1'b1, E_MRD);
        add(6'h2B, 6'h00, 1'b0, 1'b0, E_WBM);

        // reset state
        @(negedge clk);
        #1;
        step("reset_outputs", 6'h00, 6'h00, 1'b0, 1'b0, E_ZERO);
        check_cnt("reset_cnt", 32'd0);
        reset = 1'b1;

        for (int i = 0; i < n_vec; i++) begin
            step($sformatf("vec%0d", i), tbl[i].opc, tbl[i].func, tbl[i].zero, tbl[i].rdy, tbl[i].exp);
        end
        check_cnt("table_cnt", 32'd14);

        // lw with three wait cycles: 8 cycles total
        step("lw_w_fetch", 6'h23, 6'h00, 1'b0, 1'b0, E_F);
        step("lw_w_dec",   6'h23, 6'h00, 1'b0, 1'b0, E_D0);
        step("lw_w_exec",  6'h23, 6'h00, 1'b0, 1'b0, E_MEMEX);
        for (int i = 0; i < 3; i++) step($sformatf("lw_w_wait%0d", i), 6'h23, 6'h00, 1'b0, 1'b0, E_MRD);
        step("lw_w_ready", 6'h23, 6'h00, 1'b0, 1'b1, E_MRD);
        step("lw_w_wb",    6'h23, 6'h00, 1'b0, 1'b0, E_WBM);
        check_cnt("lw_wait_cnt", 32'd15);

        // sw with ready stuck low: 16 MEM_WR cycles, error on the last
        step("sw_to_fetch", 6'h2B, 6'h00, 1'b0, 1'b0, E_F);
        step("sw_to_dec",   6'h2B, 6'h00, 1'b0, 1'b0, E_D0);
        step("sw_to_exec",  6'h2B, 6'h00, 1'b0, 1'b0, E_MEMEX);
        for (int i = 0; i < 15; i++) step($sformatf("sw_to_wait%0d", i), 6'h2B, 6'h00, 1'b0, 1'b0, E_MWW);
        step("sw_to_err",   6'h2B, 6'h00, 1'b0, 1'b0, E_MWERR);
        check_cnt("sw_timeout_cnt", 32'd15);

        // sw with ready arriving exactly on the timeout cycle completes normally
        step("sw_rt_fetch", 6'h2B, 6'h00, 1'b0, 1'b0, E_F);
        step("sw_rt_dec",   6'h2B, 6'h00, 1'b0, 1'b0, E_D0);
        step("sw_rt_exec",  6'h2B, 6'h00, 1'b0, 1'b0, E_MEMEX);
        for (int i = 0; i < 15; i++) step($sformatf("sw_rt_wait%0d", i), 6'h2B, 6'h00, 1'b0, 1'b0, E_MWW);
        step("sw_rt_ready", 6'h2B, 6'h00, 1'b0, 1'b1, E_MWRET);
        check_cnt("sw_ready_last_cnt", 32'd16);

        // reset pulse during an lw wait
        step("rst_fetch", 6'h23, 6'h00, 1'b0, 1'b0, E_F);
        step("rst_dec",   6'h23, 6'h00, 1'b0, 1'b0, E_D0);
        step("rst_exec",  6'h23, 6'h00, 1'b0, 1'b0, E_MEMEX);
        step("rst_wait0", 6'h23, 6'h00, 1'b0, 1'b0, E_MRD);
        reset = 1'b0;
        #1;
        n_cmp = n_cmp + 1;
        if ({ir_we, pc_we, npc_slc, regwrite, memread, retire, mem_err, state} !== 11'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL rst_async: outputs got %b want 0", {ir_we, pc_we, npc_slc, regwrite, memread, retire, mem_err, state});
        end
        check_cnt("rst_async_cnt", 32'd0);
        #1;
        reset = 1'b1;
        step("rst_after_fetch", 6'h03, 6'h00, 1'b0, 1'b1, E_F);

        // jal then illegal opcode
        step("jal_dec",  6'h03, 6'h00, 1'b0, 1'b0, E_JAL);
        step("ill_fetch", 6'h3F, 6'h00, 1'b0, 1'b0, E_F);
        step("ill_dec",  6'h3F, 6'h00, 1'b0, 1'b0, E_NOPD);
        check_cnt("jal_ill_cnt", 32'd2);
        step("end_fetch", 6'h00, 6'h00, 1'b0, 1'b0, E_F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
